// File: rtl/ram_host_port.sv
// Host-side loader/unloader for one port of the shared operand RAM: packs BUS-bit beats into DATA-bit words and back.
// Define RAM_HOST_PORT_READBACK_EN to build the read (unload) path; otherwise read commands are accepted and dropped.
module ram_host_port #(
  parameter int DATA = 198,
  parameter int ADDR = 6,
  parameter int BUS  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_wr,
  input  logic [ADDR-1:0] cmd_addr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BUS-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BUS-1:0]  out_data,
  output logic            out_last,
  output logic            ram_wr,
  output logic [ADDR-1:0] ram_addr,
  output logic [DATA-1:0] ram_din,
  input  logic [DATA-1:0] ram_dout,
  output logic            busy
);

  localparam int BEATS = (DATA + BUS - 1) / BUS;
  localparam int SRW   = BEATS * BUS;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, READ, CAPT, SEND} state_t;

  state_t          state, state_next;
  logic [SRW-1:0]  sr;
  logic [CW-1:0]   cnt;
  logic [ADDR-1:0] addr_q;
  logic            cmd_accept, in_accept, beat_accept, last_beat;

  assign cmd_ready  = (state == IDLE);
  assign in_ready   = (state == LOAD);
  assign busy       = (state != IDLE);
  assign cmd_accept = cmd_valid && cmd_ready;
  assign in_accept  = in_valid && in_ready;
  assign last_beat  = (cnt == CW'(BEATS - 1));

  // Gated by reset so a reset landing on the WRITE cycle never reaches the RAM.
  assign ram_wr   = (state == WRITE) && !reset;
  assign ram_addr = addr_q;
  assign ram_din  = sr[DATA-1:0];

`ifdef RAM_HOST_PORT_READBACK_EN
  logic out_accept;

  assign out_valid   = (state == SEND);
  assign out_accept  = out_valid && out_ready;
  assign out_data    = out_valid ? sr[BUS-1:0] : '0;
  assign out_last    = out_valid && last_beat;
  assign beat_accept = in_accept || out_accept;
`else
  logic unused_read_path;

  assign out_valid        = 1'b0;
  assign out_data         = '0;
  assign out_last         = 1'b0;
  assign beat_accept      = in_accept;
  assign unused_read_path = out_ready ^ (^ram_dout);
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      addr_q <= '0;
    end else begin
      state <= state_next;
      if (cmd_accept)
        addr_q <= cmd_addr;

      if (cmd_accept)
        cnt <= '0;
      else if (beat_accept)
        cnt <= last_beat ? '0 : cnt + 1'b1;

      // Beats enter at the top, so the first beat ends up least significant.
      if (in_accept)
        sr <= {in_data, sr[SRW-1:BUS]};
`ifdef RAM_HOST_PORT_READBACK_EN
      else if (state == CAPT)
        sr <= SRW'(ram_dout);
      else if (out_accept)
        sr <= sr >> BUS;
`endif
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_wr)
            state_next = LOAD;
`ifdef RAM_HOST_PORT_READBACK_EN
          else
            state_next = READ;
`endif
        end
      end
      LOAD:    if (in_accept && last_beat) state_next = WRITE;
      WRITE:   state_next = IDLE;
`ifdef RAM_HOST_PORT_READBACK_EN
      READ:    state_next = CAPT;
      CAPT:    state_next = SEND;
      SEND:    if (out_accept && last_beat) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

endmodule
